// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial unsigned adder sequencer built on one full-adder cell

module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bit_idx
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             start_q;
    logic             start_edge;
    logic             last_bit;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             cell_cout;
    logic             cell_sum;

    // start_q resets high so a start level held through reset is not seen as an edge.
    assign start_edge = start & ~start_q;
    assign last_bit   = (bit_idx == 4'(WIDTH - 1));
    assign busy       = (state == ADD);
    assign done       = (state == DONE);

    fulladder u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .c_out (cell_cout),
        .sum   (cell_sum)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_sum;
        end else begin : g_res_wn
            assign res_next = {cell_sum, res_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register; reset aborts any running addition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: edges are only honoured from IDLE or DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = ADD;
            ADD:     if (last_bit)   state_next = DONE;
            DONE:    if (start_edge) state_next = ADD;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand load, one bit per cycle through the cell, result capture at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            bit_idx <= 4'd0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= 1'b0;
                        bit_idx <= 4'd0;
                    end
                end
                ADD: begin
                    carry  <= cell_cout;
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    if (last_bit) begin
                        sum     <= res_next;
                        cout    <= cell_cout;
                        bit_idx <= 4'd0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: begin
                    bit_idx <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=2 and WIDTH=8)

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst2, start2, cout2, busy2, done2;
    logic [1:0] a2, b2, sum2;
    logic [3:0] bit_idx2;
    logic       rst8, start8, cout8, busy8, done8;
    logic [7:0] a8, b8, sum8;
    logic [3:0] bit_idx8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
    } exp_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] s;
        logic       c;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2),
        .sum(sum2), .cout(cout2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
    );

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8), .bit_idx(bit_idx8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard entry and compares it with the settled result.
    task automatic compare_result(input string tag, input logic [7:0] s_act, input logic c_act);
        exp_t e;
        check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(s_act), 32'(e.s));
            check({tag, "_cout"}, 32'(c_act), 32'(e.c));
        end
    endtask

    // One start pulse on the WIDTH=2 instance; previous result must hold while busy.
    task automatic run_add2(input logic [1:0] av, input logic [1:0] bv, input string tag);
        logic [1:0] ps;
        logic       pc;
        int         n;
        ps = sum2;
        pc = cout2;
        a2 = av;
        b2 = bv;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check({tag, "_done_drop"}, 32'(done2), 32'd0);
        n = 0;
        while (busy2 && n < 20) begin
            check({tag, "_sum_hold"}, 32'(sum2), 32'(ps));
            check({tag, "_cout_hold"}, 32'(cout2), 32'(pc));
            n++;
            tick;
        end
        check({tag, "_busy_len"}, 32'(n), 32'd2);
        check({tag, "_done"}, 32'(done2), 32'd1);
        compare_result(tag, 8'(sum2), cout2);
    endtask

    // Structural invariants on both instances, sampled away from the rising edge.
    always @(negedge clk) begin
        if (!rst2) begin
            checks++;
            if ((busy2 && done2) || (busy2 && bit_idx2 >= 4'd2) || (!busy2 && bit_idx2 != 4'd0)) begin
                failures++;
                $display("FAIL inv2 actual=busy%0d done%0d idx%0d required=exclusive,idx<2", busy2, done2, bit_idx2);
            end
        end
        if (!rst8) begin
            checks++;
            if ((busy8 && done8) || (busy8 && bit_idx8 >= 4'd8) || (!busy8 && bit_idx8 != 4'd0)) begin
                failures++;
                $display("FAIL inv8 actual=busy%0d done%0d idx%0d required=exclusive,idx<8", busy8, done8, bit_idx8);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   nb;
        logic [2:0] tot;

        for (int i = 0; i < 16; i++) begin
            vecs[i].a = 2'(i / 4);
            vecs[i].b = 2'(i % 4);
            tot = 3'(i / 4) + 3'(i % 4);
            vecs[i].s = tot[1:0];
            vecs[i].c = tot[2];
        end

        rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        tick;
        tick;
        check("rst_sum", 32'(sum2), 32'd0);
        check("rst_cout", 32'(cout2), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_idx", 32'(bit_idx2), 32'd0);
        rst2 = 1'b0;
        rst8 = 1'b0;
        tick;

        // Sweep all operand pairs; last entry is 3+3.
        for (int i = 0; i < 16; i++) begin
            e.s = 8'(vecs[i].s);
            e.c = vecs[i].c;
            exp_q.push_back(e);
            run_add2(vecs[i].a, vecs[i].b, $sformatf("sweep%0d", i));
        end

        // Restart from DONE after 3+3: old 2'b10/1 must hold until new done.
        e.s = 8'd1; e.c = 1'b0;
        exp_q.push_back(e);
        run_add2(2'd0, 2'd1, "restart");

        // Level start held high: exactly one addition.
        e.s = 8'd3; e.c = 1'b0;
        exp_q.push_back(e);
        a2 = 2'd1; b2 = 2'd2; start2 = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (busy2) nb++;
        end
        check("level_busy_cnt", 32'(nb), 32'd2);
        check("level_done", 32'(done2), 32'd1);
        compare_result("level", 8'(sum2), cout2);
        start2 = 1'b0;
        tick;

        // Second edge during ADD with changed operands is ignored.
        e.s = 8'd2; e.c = 1'b0;
        exp_q.push_back(e);
        a2 = 2'd1; b2 = 2'd1; start2 = 1'b1;
        tick;
        check("ign_busy0", 32'(busy2), 32'd1);
        start2 = 1'b0; a2 = 2'd3; b2 = 2'd3;
        tick;
        check("ign_busy1", 32'(busy2), 32'd1);
        start2 = 1'b1;
        tick;
        check("ign_end_busy", 32'(busy2), 32'd0);
        check("ign_end_done", 32'(done2), 32'd1);
        start2 = 1'b0;
        tick;
        tick;
        check("ign_no_retrig", 32'(done2), 32'd1);
        compare_result("ign", 8'(sum2), cout2);

        // WIDTH=8: establish a nonzero result, then abort a run mid-way.
        e.s = 8'h46; e.c = 1'b0;
        exp_q.push_back(e);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            n++;
            tick;
        end
        check("w8_pre_done", 32'(done8), 32'd1);
        compare_result("w8_pre", sum8, cout8);

        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        n = 0;
        while (bit_idx8 != 4'd3 && n < 40) begin
            n++;
            tick;
        end
        check("w8_reach_idx3", 32'(bit_idx8), 32'd3);
        rst8 = 1'b1;
        tick;
        check("w8_rst_sum", 32'(sum8), 32'd0);
        check("w8_rst_cout", 32'(cout8), 32'd0);
        check("w8_rst_busy", 32'(busy8), 32'd0);
        check("w8_rst_done", 32'(done8), 32'd0);
        check("w8_rst_idx", 32'(bit_idx8), 32'd0);
        rst8 = 1'b0;
        tick;
        tick;
        check("w8_idle_done", 32'(done8), 32'd0);

        e.s = 8'h00; e.c = 1'b1;
        exp_q.push_back(e);
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            tick;
        end
        check("w8_busy_len", 32'(n), 32'd8);
        check("w8_done", 32'(done8), 32'd1);
        compare_result("w8_post", sum8, cout8);

        check("q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
